// File: rtl/rxuartlite_sync.sv
// rxuartlite_sync: minimal 8N1 UART receiver with a two-flop input synchroniser and mid-baud sampling.
// Each received byte is presented as a one-cycle o_wr strobe with data and a framing-error flag.
module rxuartlite_sync #(
    parameter [4:0]    TIMING_BITS     = 5'd24,
    parameter          TB              = TIMING_BITS,
    parameter [TB-1:0] CLOCKS_PER_BAUD = TB'(8)
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);
    typedef enum logic [3:0] {
        BIT0      = 4'h0,
        BIT1      = 4'h1,
        BIT2      = 4'h2,
        BIT3      = 4'h3,
        BIT4      = 4'h4,
        BIT5      = 4'h5,
        BIT6      = 4'h6,
        BIT7      = 4'h7,
        STOP      = 4'h8,
        START     = 4'hd,
        WAIT_HIGH = 4'he,
        IDLE      = 4'hf
    } state_t;

    localparam [TB-1:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - TB'(1);
    localparam [TB-1:0] BAUD_LOAD = CLOCKS_PER_BAUD - TB'(1);

    state_t        state;
    logic [TB-1:0] baud_counter;
    logic [7:0]    shift;
    logic          ck_1, ck_2;

    assign o_busy = state != IDLE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ck_1         <= 1'b1;
            ck_2         <= 1'b1;
            state        <= WAIT_HIGH;
            baud_counter <= '0;
            shift        <= 8'h00;
            o_wr         <= 1'b0;
            o_data       <= 8'h00;
            o_frame_err  <= 1'b0;
        end else begin
            ck_1 <= i_uart_rx;
            ck_2 <= ck_1;
            o_wr <= 1'b0;
            if (state == WAIT_HIGH) begin
                baud_counter <= '0;
                if (ck_2)
                    state <= IDLE;
            end else if (state == IDLE) begin
                baud_counter <= ck_2 ? '0 : HALF_LOAD;
                if (!ck_2)
                    state <= START;
            end else if (baud_counter != '0) begin
                baud_counter <= baud_counter - TB'(1);
            end else if (state == START) begin
                // A start bit that has gone high by mid-bit was a glitch
                baud_counter <= ck_2 ? '0 : BAUD_LOAD;
                state        <= ck_2 ? IDLE : BIT0;
            end else if (state == STOP) begin
                o_wr        <= 1'b1;
                o_data      <= shift;
                o_frame_err <= !ck_2;
                state       <= ck_2 ? IDLE : WAIT_HIGH;
            end else if (state <= BIT7) begin
                shift        <= {ck_2, shift[7:1]};
                baud_counter <= BAUD_LOAD;
                state        <= (state == BIT7) ? STOP : state_t'(state + 4'd1);
            end else begin
                state <= WAIT_HIGH;
            end
        end
    end
endmodule

// File: tb/tb_rxuartlite_sync.sv
// tb_rxuartlite_sync: directed frames with a scoreboard of expected bytes, flags and strobe cycles.
module tb_rxuartlite_sync;
    localparam int CPB = 8;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       o_wr, o_frame_err, o_busy;
    logic [7:0] o_data;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       sb[$];

    rxuartlite_sync #(.CLOCKS_PER_BAUD(24'd8)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_uart_rx   (rx),
        .o_wr        (o_wr),
        .o_data      (o_data),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pin falls at cycle c; synchroniser + IDLE detect puts E2 at c+3, strobe visible at c+3+4+72.
    task automatic send(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        exp_t e;
        fr = {stop, d, 1'b0};
        e.d = d;
        e.fe = !stop;
        e.cyc = cyc + 79;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            tick(CPB);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_wr) begin
            if (sb.size() == 0) begin
                check("unexpected_o_wr", {24'h0, o_data}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("o_data", {24'h0, o_data}, {24'h0, e.d});
                check("o_frame_err", {31'h0, o_frame_err}, {31'h0, e.fe});
                check("o_wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        tick(3);
        check("rst_o_wr", {31'h0, o_wr}, 32'h0);
        check("rst_o_data", {24'h0, o_data}, 32'h0);
        check("rst_o_frame_err", {31'h0, o_frame_err}, 32'h0);
        check("rst_o_busy", {31'h0, o_busy}, 32'h1);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", {31'h0, o_busy}, 32'h0);
        tick(20);

        c = cyc;
        fork
            send(8'h55, 1'b1);
            begin
                tick(2);
                check("busy_before_e2", {31'h0, o_busy}, 32'h0);
                tick(1);
                check("busy_after_e2", {31'h0, o_busy}, 32'h1);
                tick(75);
                check("busy_at_stop", {31'h0, o_busy}, 32'h1);
                tick(1);
                check("busy_after_stop", {31'h0, o_busy}, 32'h0);
            end
        join
        tick(10);
        check("start_cycle_ref", cyc - c, 32'd90);

        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
        tick(10);

        send(8'hC6, 1'b0);
        tick(20);
        check("wait_high_busy", {31'h0, o_busy}, 32'h1);
        rx = 1'b1;
        tick(4);
        check("after_break_busy", {31'h0, o_busy}, 32'h0);
        tick(10);

        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(2);
        check("glitch_busy", {31'h0, o_busy}, 32'h1);
        tick(10);
        check("glitch_idle", {31'h0, o_busy}, 32'h0);
        check("glitch_o_data", {24'h0, o_data}, 32'hC6);
        check("glitch_o_frame_err", {31'h0, o_frame_err}, 32'h1);

        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(3 * CPB + 4);
        rst_n = 1'b0;
        #1;
        check("abort_o_wr", {31'h0, o_wr}, 32'h0);
        check("abort_o_data", {24'h0, o_data}, 32'h0);
        check("abort_o_frame_err", {31'h0, o_frame_err}, 32'h0);
        check("abort_o_busy", {31'h0, o_busy}, 32'h1);
        tick(12);
        rst_n = 1'b1;
        tick(4 * CPB + 10);
        check("abort_idle", {31'h0, o_busy}, 32'h0);

        send(8'h3C, 1'b1);
        tick(20);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
